// File: rtl/coreahbltoaxi_wrch_rdctrl.sv
// Read-side controller for the write-channel data buffer of the AHB-Lite-to-AXI
// bridge. Drains 64-bit entries from the dual-half RAM one beat at a time, in
// bursts described by the AW-side issuer. Drives the AXI W channel through a
// 2-entry skid FIFO, so WREADY backpressure never stalls a RAM read already in flight.
module coreahbltoaxi_wrch_rdctrl #(
  parameter int RAM_AWIDTH = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [RAM_AWIDTH:0]   WPtr,
  output logic [RAM_AWIDTH:0]   RPtr,
  output logic [RAM_AWIDTH-1:0] RAddr,
  output logic                  Re1,
  output logic                  Re2,
  output logic                  Rempty,
  input  logic [63:0]           Rdata,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_len,
  input  logic [1:0]            cmd_first_strb,
  input  logic [1:0]            cmd_last_strb,
  output logic [63:0]           WDATA,
  output logic [7:0]            WSTRB,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [3:0]  len_q;
  logic [3:0]  beats_left_q;
  logic [1:0]  first_strb_q;
  logic [1:0]  last_strb_q;
  logic        first_q;

  logic [1:0]  beat_mask;
  logic        beat_last;
  logic        issue;
  logic        pop;
  logic        credit_ok;
  logic        fifo_valid;

  logic [RAM_AWIDTH:0] rptr_q;

  logic [63:0] slot_data_q [2];
  logic [1:0]  slot_mask_q [2];
  logic        slot_last_q [2];
  logic        slot_pend_q [2];
  logic        wr_idx_q;
  logic        rd_idx_q;
  logic [1:0]  count_q;

  // Unread RAM halves come back as X, so only enabled halves pass through.
  function automatic logic [63:0] mask_data(input logic [63:0] d, input logic [1:0] m);
    mask_data = {(m[1] ? d[63:32] : 32'h0), (m[0] ? d[31:0] : 32'h0)};
  endfunction

  assign Rempty     = (rptr_q == WPtr);
  assign RPtr       = rptr_q;
  assign RAddr      = rptr_q[RAM_AWIDTH-1:0];
  assign fifo_valid = (count_q != 2'd0);
  assign pop        = fifo_valid & WREADY;
  // A slot is reserved at issue time; a same-cycle pop frees one slot.
  assign credit_ok  = (count_q != 2'd2) | pop;
  assign issue      = (state_q == ISSUE) & ~Rempty & credit_ok;
  assign Re1        = issue & beat_mask[0];
  assign Re2        = issue & beat_mask[1];
  assign cmd_ready  = (state_q == IDLE) & ARESETn;

  // Half-word enables for the beat about to be read, from the latched command.
  always_comb begin
    beat_mask = 2'b11;
    beat_last = (beats_left_q == 4'd0);
    if (len_q == 4'd0) begin
      beat_mask = first_strb_q & last_strb_q;
    end else if (first_q) begin
      beat_mask = first_strb_q;
    end else if (beats_left_q == 4'd0) begin
      beat_mask = last_strb_q;
    end
  end

  // State register for the burst sequencer.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept a command, issue every read, then wait for WLAST.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (issue && (beats_left_q == 4'd0)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && WLAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the burst command and count beats down as their reads are issued.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      len_q        <= 4'd0;
      beats_left_q <= 4'd0;
      first_strb_q <= 2'b00;
      last_strb_q  <= 2'b00;
      first_q      <= 1'b0;
    end else if ((state_q == IDLE) && cmd_valid) begin
      len_q        <= cmd_len;
      beats_left_q <= cmd_len;
      first_strb_q <= cmd_first_strb;
      last_strb_q  <= cmd_last_strb;
      first_q      <= 1'b1;
    end else if (issue && (beats_left_q != 4'd0)) begin
      beats_left_q <= beats_left_q - 4'd1;
      first_q      <= 1'b0;
    end
  end

  // Read pointer advances once per issued read, wrapping through its MSB.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rptr_q <= '0;
    end else if (issue) begin
      rptr_q <= rptr_q + 1'b1;
    end
  end

  // Skid FIFO: a slot is claimed on issue and filled from Rdata one cycle later.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < 2; i++) begin
        slot_data_q[i] <= 64'h0;
        slot_mask_q[i] <= 2'b00;
        slot_last_q[i] <= 1'b0;
        slot_pend_q[i] <= 1'b0;
      end
      wr_idx_q <= 1'b0;
      rd_idx_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (slot_pend_q[i]) begin
          slot_data_q[i] <= mask_data(Rdata, slot_mask_q[i]);
          slot_pend_q[i] <= 1'b0;
        end
      end
      if (issue) begin
        slot_mask_q[wr_idx_q] <= beat_mask;
        slot_last_q[wr_idx_q] <= beat_last;
        slot_pend_q[wr_idx_q] <= 1'b1;
        wr_idx_q              <= ~wr_idx_q;
      end
      if (pop) begin
        rd_idx_q <= ~rd_idx_q;
      end
      count_q <= count_q + {1'b0, issue} - {1'b0, pop};
    end
  end

  // W channel driven from the FIFO head; a freshly read head bypasses Rdata.
  always_comb begin
    WVALID = fifo_valid;
    WDATA  = 64'h0;
    WSTRB  = 8'h00;
    WLAST  = 1'b0;
    if (fifo_valid) begin
      WSTRB = {{4{slot_mask_q[rd_idx_q][1]}}, {4{slot_mask_q[rd_idx_q][0]}}};
      WLAST = slot_last_q[rd_idx_q];
      WDATA = slot_pend_q[rd_idx_q] ? mask_data(Rdata, slot_mask_q[rd_idx_q])
                                    : slot_data_q[rd_idx_q];
    end
  end

endmodule

// File: tb/tb_coreahbltoaxi_wrch_rdctrl.sv
// Directed bench for the write-channel read controller, with a small RAM model
// and a W-channel monitor that records every accepted beat.
module tb_coreahbltoaxi_wrch_rdctrl;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [4:0]  WPtr;
  logic [4:0]  RPtr;
  logic [3:0]  RAddr;
  logic        Re1;
  logic        Re2;
  logic        Rempty;
  logic [63:0] Rdata;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_len;
  logic [1:0]  cmd_first_strb;
  logic [1:0]  cmd_last_strb;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_rptr = 5'd0;

  logic [31:0] mem_lo [16];
  logic [31:0] mem_hi [16];

  int cyc = 0;
  int beat_cnt = 0;
  int stall_err = 0;
  int over_cnt = 0;
  int rise_cnt = 0;
  int re2_cnt = 0;
  int issued = 0;
  int accepted = 0;
  logic [63:0] beat_data [128];
  logic [7:0]  beat_strb [128];
  logic        beat_last [128];
  int          beat_time [128];
  logic        prev_stall = 1'b0;
  logic        prev_valid = 1'b0;
  logic [63:0] prev_data = 64'h0;
  logic [7:0]  prev_strb = 8'h0;
  logic        prev_last = 1'b0;

  coreahbltoaxi_wrch_rdctrl #(.RAM_AWIDTH(4)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .WPtr(WPtr), .RPtr(RPtr), .RAddr(RAddr),
    .Re1(Re1), .Re2(Re2), .Rempty(Rempty), .Rdata(Rdata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_first_strb(cmd_first_strb), .cmd_last_strb(cmd_last_strb),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY)
  );

  always #5 ACLK = ~ACLK;

  // RAM model: registered read per half; a half that is not read returns X.
  always @(posedge ACLK) begin
    Rdata[31:0]  <= Re1 ? mem_lo[RAddr] : 32'hx;
    Rdata[63:32] <= Re2 ? mem_hi[RAddr] : 32'hx;
  end

  // Monitor: records accepted beats, hold-while-stalled violations and outstanding reads.
  always @(negedge ACLK) begin
    cyc++;
    if (!ARESETn) begin
      issued = 0;
      accepted = 0;
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (prev_stall && (!WVALID || WDATA !== prev_data || WSTRB !== prev_strb || WLAST !== prev_last))
        stall_err++;
      if (WVALID && !prev_valid) rise_cnt++;
      if (Re2) re2_cnt++;
      if (Re1 || Re2) issued++;
      if (WVALID && WREADY) begin
        if (beat_cnt < 128) begin
          beat_data[beat_cnt] = WDATA;
          beat_strb[beat_cnt] = WSTRB;
          beat_last[beat_cnt] = WLAST;
          beat_time[beat_cnt] = cyc;
        end
        beat_cnt++;
        accepted++;
      end
      if (issued - accepted > 2) over_cnt++;
      prev_stall = WVALID && !WREADY;
      prev_valid = WVALID;
      prev_data  = WDATA;
      prev_strb  = WSTRB;
      prev_last  = WLAST;
    end
  end

  task automatic stepCycle();
    @(posedge ACLK);
    #1;
  endtask

  task automatic writeEntry(input logic [31:0] lo, input logic [31:0] hi);
    mem_lo[WPtr[3:0]] = lo;
    mem_hi[WPtr[3:0]] = hi;
    WPtr = WPtr + 5'd1;
  endtask

  task automatic applyStimulus(input logic [3:0] len, input logic [1:0] fs, input logic [1:0] ls,
                               output bit ok);
    cmd_len = len;
    cmd_first_strb = fs;
    cmd_last_strb = ls;
    cmd_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (cmd_ready) ok = 1'b1;
      stepCycle();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic waitBeats(input int target, input int budget, output bit ok);
    int n;
    n = 0;
    while (beat_cnt < target && n < budget) begin
      @(negedge ACLK);
      #1;
      n++;
    end
    ok = (beat_cnt >= target);
  endtask

  task automatic test_reset();
    #12;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_cmd_ready got %b want 0", cmd_ready); end
    checks++; if (WVALID !== 1'b0) begin errors++; $display("[TB] FAIL reset_wvalid got %b want 0", WVALID); end
    checks++; if (WLAST !== 1'b0) begin errors++; $display("[TB] FAIL reset_wlast got %b want 0", WLAST); end
    checks++; if (WSTRB !== 8'h00) begin errors++; $display("[TB] FAIL reset_wstrb got %h want 00", WSTRB); end
    checks++; if (WDATA !== 64'h0) begin errors++; $display("[TB] FAIL reset_wdata got %h want 0", WDATA); end
    checks++; if (RPtr !== 5'd0) begin errors++; $display("[TB] FAIL reset_rptr got %0d want 0", RPtr); end
    checks++; if ({Re2, Re1} !== 2'b00) begin errors++; $display("[TB] FAIL reset_re got %b want 00", {Re2, Re1}); end
    checks++; if (Rempty !== 1'b1) begin errors++; $display("[TB] FAIL reset_rempty got %b want 1", Rempty); end
    @(negedge ACLK);
    ARESETn = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_ready got %b want 1", cmd_ready); end
  endtask

  task automatic test_single();
    int base;
    int r2;
    bit ok;
    base = beat_cnt;
    r2 = re2_cnt;
    writeEntry(32'h11111111, 32'h22222222);
    applyStimulus(4'd0, 2'b01, 2'b01, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL single_cmd handshake got 0 want 1"); end
    waitBeats(base + 1, 20, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL single_timeout beats %0d want %0d", beat_cnt - base, 1); end
    checks++; if (beat_data[base] !== 64'h00000000_11111111) begin errors++; $display("[TB] FAIL single_wdata got %h want 0000000011111111", beat_data[base]); end
    checks++; if (beat_strb[base] !== 8'h0F) begin errors++; $display("[TB] FAIL single_wstrb got %h want 0f", beat_strb[base]); end
    checks++; if (beat_last[base] !== 1'b1) begin errors++; $display("[TB] FAIL single_wlast got %b want 1", beat_last[base]); end
    repeat (3) stepCycle();
    exp_rptr = exp_rptr + 5'd1;
    checks++; if (re2_cnt - r2 != 0) begin errors++; $display("[TB] FAIL single_re2 got %0d cycles want 0", re2_cnt - r2); end
    checks++; if (RPtr !== exp_rptr) begin errors++; $display("[TB] FAIL single_rptr got %0d want %0d", RPtr, exp_rptr); end
    checks++; if (Rempty !== 1'b1) begin errors++; $display("[TB] FAIL single_rempty got %b want 1", Rempty); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_idle got %b want 1", cmd_ready); end
  endtask

  task automatic test_burst4();
    int base;
    bit ok;
    logic [63:0] ed;
    logic [7:0] es;
    base = beat_cnt;
    for (int k = 0; k < 4; k++) writeEntry(32'hA0000000 + k, 32'hB0000000 + k);
    applyStimulus(4'd3, 2'b10, 2'b01, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL burst4_cmd handshake got 0 want 1"); end
    waitBeats(base + 4, 30, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL burst4_timeout beats %0d want 4", beat_cnt - base); end
    for (int k = 0; k < 4; k++) begin
      es = (k == 0) ? 8'hF0 : (k == 3) ? 8'h0F : 8'hFF;
      ed = {((k == 3) ? 32'h0 : 32'hB0000000 + k), ((k == 0) ? 32'h0 : 32'hA0000000 + k)};
      checks++; if (beat_data[base+k] !== ed) begin errors++; $display("[TB] FAIL burst4_wdata beat %0d got %h want %h", k, beat_data[base+k], ed); end
      checks++; if (beat_strb[base+k] !== es) begin errors++; $display("[TB] FAIL burst4_wstrb beat %0d got %h want %h", k, beat_strb[base+k], es); end
      checks++; if (beat_last[base+k] !== (k == 3)) begin errors++; $display("[TB] FAIL burst4_wlast beat %0d got %b want %b", k, beat_last[base+k], (k == 3)); end
    end
    checks++; if (beat_time[base+3] - beat_time[base] != 3) begin errors++; $display("[TB] FAIL burst4_back2back span %0d cycles want 3", beat_time[base+3] - beat_time[base]); end
    repeat (2) stepCycle();
    exp_rptr = exp_rptr + 5'd4;
    checks++; if (RPtr !== exp_rptr) begin errors++; $display("[TB] FAIL burst4_rptr got %0d want %0d", RPtr, exp_rptr); end
  endtask

  task automatic test_backpressure();
    int base;
    int st;
    int oc;
    int i;
    bit ok;
    logic [5:0] patv;
    logic [63:0] ed;
    patv = 6'b101001;
    base = beat_cnt;
    st = stall_err;
    oc = over_cnt;
    for (int k = 0; k < 8; k++) writeEntry(32'hC0000000 + k, 32'hD0000000 + k);
    applyStimulus(4'd7, 2'b11, 2'b11, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL bp_cmd handshake got 0 want 1"); end
    i = 0;
    while (beat_cnt < base + 8 && i < 80) begin
      WREADY = patv[i % 6];
      stepCycle();
      i++;
    end
    WREADY = 1'b1;
    repeat (4) stepCycle();
    checks++; if (beat_cnt - base != 8) begin errors++; $display("[TB] FAIL bp_count got %0d want 8", beat_cnt - base); end
    for (int k = 0; k < 8; k++) begin
      ed = {32'hD0000000 + k, 32'hC0000000 + k};
      checks++; if (beat_data[base+k] !== ed) begin errors++; $display("[TB] FAIL bp_wdata beat %0d got %h want %h", k, beat_data[base+k], ed); end
      checks++; if (beat_last[base+k] !== (k == 7)) begin errors++; $display("[TB] FAIL bp_wlast beat %0d got %b want %b", k, beat_last[base+k], (k == 7)); end
    end
    checks++; if (stall_err - st != 0) begin errors++; $display("[TB] FAIL bp_hold got %0d unstable cycles want 0", stall_err - st); end
    checks++; if (over_cnt - oc != 0) begin errors++; $display("[TB] FAIL bp_outstanding got %0d cycles above 2 want 0", over_cnt - oc); end
    exp_rptr = exp_rptr + 5'd8;
    checks++; if (RPtr !== exp_rptr) begin errors++; $display("[TB] FAIL bp_rptr got %0d want %0d", RPtr, exp_rptr); end
  endtask

  task automatic test_underflow();
    int base;
    int rc;
    bit ok;
    logic [63:0] ed;
    base = beat_cnt;
    rc = rise_cnt;
    writeEntry(32'hE0000000, 32'hF0000000);
    writeEntry(32'hE0000001, 32'hF0000001);
    applyStimulus(4'd3, 2'b11, 2'b11, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL uf_cmd handshake got 0 want 1"); end
    repeat (5) stepCycle();
    writeEntry(32'hE0000002, 32'hF0000002);
    writeEntry(32'hE0000003, 32'hF0000003);
    waitBeats(base + 4, 30, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL uf_timeout beats %0d want 4", beat_cnt - base); end
    for (int k = 0; k < 4; k++) begin
      ed = {32'hF0000000 + k, 32'hE0000000 + k};
      checks++; if (beat_data[base+k] !== ed) begin errors++; $display("[TB] FAIL uf_wdata beat %0d got %h want %h", k, beat_data[base+k], ed); end
      checks++; if (beat_last[base+k] !== (k == 3)) begin errors++; $display("[TB] FAIL uf_wlast beat %0d got %b want %b", k, beat_last[base+k], (k == 3)); end
    end
    checks++; if (rise_cnt - rc != 2) begin errors++; $display("[TB] FAIL uf_wvalid_gap rises %0d want 2", rise_cnt - rc); end
    repeat (2) stepCycle();
    exp_rptr = exp_rptr + 5'd4;
    checks++; if (RPtr !== exp_rptr) begin errors++; $display("[TB] FAIL uf_rptr got %0d want %0d", RPtr, exp_rptr); end
  endtask

  task automatic test_wrap();
    int base;
    bit ok;
    logic [63:0] ed;
    logic [3:0] ea;
    for (int k = 0; k < 20; k++) begin
      base = beat_cnt;
      writeEntry(32'h00001000 + k, 32'h00002000 + k);
      #1;
      ea = exp_rptr[3:0];
      checks++; if (Rempty !== 1'b0) begin errors++; $display("[TB] FAIL wrap_notempty iter %0d got %b want 0", k, Rempty); end
      checks++; if (RAddr !== ea) begin errors++; $display("[TB] FAIL wrap_raddr iter %0d got %0d want %0d", k, RAddr, ea); end
      applyStimulus(4'd0, 2'b11, 2'b11, ok);
      waitBeats(base + 1, 20, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL wrap_timeout iter %0d", k); end
      ed = {32'h00002000 + k, 32'h00001000 + k};
      checks++; if (beat_data[base] !== ed) begin errors++; $display("[TB] FAIL wrap_wdata iter %0d got %h want %h", k, beat_data[base], ed); end
      repeat (2) stepCycle();
      exp_rptr = exp_rptr + 5'd1;
      checks++; if (RPtr !== exp_rptr) begin errors++; $display("[TB] FAIL wrap_rptr iter %0d got %0d want %0d", k, RPtr, exp_rptr); end
      checks++; if (Rempty !== 1'b1) begin errors++; $display("[TB] FAIL wrap_empty iter %0d got %b want 1", k, Rempty); end
    end
  endtask

  task automatic test_reset_midburst();
    int base;
    bit ok;
    base = beat_cnt;
    for (int k = 0; k < 4; k++) writeEntry(32'h30000000 + k, 32'h40000000 + k);
    applyStimulus(4'd3, 2'b11, 2'b11, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL rst_cmd handshake got 0 want 1"); end
    waitBeats(base + 2, 20, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL rst_timeout beats %0d want 2", beat_cnt - base); end
    #1;
    ARESETn = 1'b0;
    WPtr = 5'd0;
    #1;
    checks++; if (WVALID !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_wvalid got %b want 0", WVALID); end
    checks++; if ({Re2, Re1} !== 2'b00) begin errors++; $display("[TB] FAIL rst_async_re got %b want 00", {Re2, Re1}); end
    checks++; if (RPtr !== 5'd0) begin errors++; $display("[TB] FAIL rst_async_rptr got %0d want 0", RPtr); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_ready got %b want 0", cmd_ready); end
    exp_rptr = 5'd0;
    @(negedge ACLK);
    @(negedge ACLK);
    ARESETn = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_idle got %b want 1", cmd_ready); end
    checks++; if (Rempty !== 1'b1) begin errors++; $display("[TB] FAIL rst_rempty got %b want 1", Rempty); end
  endtask

  task automatic test_after_reset();
    int base;
    bit ok;
    base = beat_cnt;
    writeEntry(32'h55555555, 32'h66666666);
    applyStimulus(4'd0, 2'b10, 2'b10, ok);
    waitBeats(base + 1, 20, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL post_timeout beats %0d want 1", beat_cnt - base); end
    checks++; if (beat_data[base] !== 64'h66666666_00000000) begin errors++; $display("[TB] FAIL post_wdata got %h want 6666666600000000", beat_data[base]); end
    checks++; if (beat_strb[base] !== 8'hF0) begin errors++; $display("[TB] FAIL post_wstrb got %h want f0", beat_strb[base]); end
    checks++; if (beat_last[base] !== 1'b1) begin errors++; $display("[TB] FAIL post_wlast got %b want 1", beat_last[base]); end
    repeat (2) stepCycle();
    exp_rptr = exp_rptr + 5'd1;
    checks++; if (RPtr !== exp_rptr) begin errors++; $display("[TB] FAIL post_rptr got %0d want %0d", RPtr, exp_rptr); end
  endtask

  // Sequence the scenarios and report the totals.
  initial begin
    WPtr = 5'd0;
    WREADY = 1'b1;
    cmd_valid = 1'b0;
    cmd_len = 4'd0;
    cmd_first_strb = 2'b00;
    cmd_last_strb = 2'b00;
    test_reset();
    test_single();
    test_burst4();
    test_backpressure();
    test_underflow();
    test_wrap();
    test_reset_midburst();
    test_after_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case a scenario never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

endmodule
